// File: rtl/unidade_controle_multicanal.sv
// unidade_controle_multicanal: multi-channel measurement sequencer.
// Clears the datapath, strobes each channel's register enable in turn, counts
// for a latched number of cycles (or until fim_contador), then flags completion.
// Optional build macro: UNIDADE_CONTROLE_DB_ESTADO_EN adds the db_estado debug port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// INICIAL  | idle; waits for iniciar
// ZERA     | one-cycle datapath clear; latches limite (0 stored as 1)
// REGISTRA | one-hot registra strobe per channel, N_CANAIS cycles
// CONTA    | count enable; exits on contagem+1 == limite_reg or fim_contador
// FINAL    | one-cycle pronto; continuo selects restart or idle
module unidade_controle_multicanal #(
  parameter int N_CANAIS = 4,
  parameter int LARGURA  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                parar,
  input  logic                continuo,
  input  logic [LARGURA-1:0]  limite,
  input  logic                fim_contador,
  output logic                zera,
  output logic [N_CANAIS-1:0] registra,
  output logic                conta,
  output logic [LARGURA-1:0]  contagem,
  output logic                pronto,
  output logic                ocupado
`ifdef UNIDADE_CONTROLE_DB_ESTADO_EN
  ,
  output logic [2:0]          db_estado
`endif
);

  localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ZERA     = 3'd1,
    REGISTRA = 3'd2,
    CONTA    = 3'd3,
    FINAL    = 3'd4
  } estado_t;

  estado_t            estado, estado_prox;
  logic [CW-1:0]      canal;
  logic [LARGURA-1:0] limite_reg;
  logic [LARGURA-1:0] contagem_reg;
  logic [LARGURA-1:0] contagem_inc;
  logic               canal_ultimo;
  logic               fim_conta;

  assign contagem_inc = contagem_reg + 1'b1;
  assign canal_ultimo = (canal == CW'(N_CANAIS - 1));
  // limite_reg never exceeds 2^LARGURA-1, so contagem_inc cannot wrap before exit
  assign fim_conta    = (contagem_inc == limite_reg) || fim_contador;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state decode; parar overrides every transition
  always_comb begin
    estado_prox = estado;
    if (parar) begin
      estado_prox = INICIAL;
    end else begin
      case (estado)
        INICIAL:  if (iniciar) estado_prox = ZERA;
        ZERA:     estado_prox = REGISTRA;
        REGISTRA: if (canal_ultimo) estado_prox = CONTA;
        CONTA:    if (fim_conta) estado_prox = FINAL;
        FINAL:    estado_prox = continuo ? ZERA : INICIAL;
        default:  estado_prox = INICIAL;
      endcase
    end
  end

  // Channel index, latched limit and internal counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      canal        <= '0;
      limite_reg   <= '0;
      contagem_reg <= '0;
    end else if (parar) begin
      canal <= '0;
    end else begin
      case (estado)
        ZERA: begin
          canal        <= '0;
          contagem_reg <= '0;
          limite_reg   <= (limite == '0) ? LARGURA'(1) : limite;
        end
        REGISTRA: begin
          canal <= canal_ultimo ? '0 : canal + 1'b1;
        end
        CONTA: begin
          contagem_reg <= contagem_inc;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from registered state
  always_comb begin
    zera    = (estado == ZERA);
    conta   = (estado == CONTA);
    pronto  = (estado == FINAL);
    ocupado = (estado != INICIAL);
    registra = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      registra[i] = (estado == REGISTRA) && (canal == CW'(i));
    end
  end

  assign contagem = contagem_reg;

`ifdef UNIDADE_CONTROLE_DB_ESTADO_EN
  assign db_estado = estado;
`endif

endmodule

// File: tb/tb_unidade_controle_multicanal.sv
// Directed bench for unidade_controle_multicanal (N_CANAIS=4, LARGURA=8).
module tb_unidade_controle_multicanal;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic       continuo;
  logic [7:0] limite;
  logic       fim_contador;
  logic       zera;
  logic [3:0] registra;
  logic       conta;
  logic [7:0] contagem;
  logic       pronto;
  logic       ocupado;
`ifdef UNIDADE_CONTROLE_DB_ESTADO_EN
  logic [2:0] db_estado;
`endif

  int n_pass  = 0;
  int n_total = 0;

  unidade_controle_multicanal #(.N_CANAIS(4), .LARGURA(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .parar        (parar),
    .continuo     (continuo),
    .limite       (limite),
    .fim_contador (fim_contador),
    .zera         (zera),
    .registra     (registra),
    .conta        (conta),
    .contagem     (contagem),
    .pronto       (pronto),
    .ocupado      (ocupado)
`ifdef UNIDADE_CONTROLE_DB_ESTADO_EN
    ,
    .db_estado    (db_estado)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare packed {zera, registra, conta, contagem, pronto, ocupado}
  task automatic chk(input string tag, input logic z, input logic [3:0] r, input logic c,
                     input logic [7:0] cnt, input logic p, input logic o);
    logic [15:0] obs, expv;
    obs  = {zera, registra, conta, contagem, pronto, ocupado};
    expv = {z, r, c, cnt, p, o};
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed z=%b r=%b c=%b cnt=%0d p=%b o=%b required z=%b r=%b c=%b cnt=%0d p=%b o=%b",
                tag, obs[15], obs[14:11], obs[10], obs[9:2], obs[1], obs[0],
                expv[15], expv[14:11], expv[10], expv[9:2], expv[1], expv[0]);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Start pulse, then checks ZERA and the four registra strobes
  task automatic run_head(input string tag, input logic [7:0] cnt_old);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk({tag, "_zera"}, 1'b1, 4'b0000, 1'b0, cnt_old, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_reg"}, 1'b0, 4'(1 << i), 1'b0, 8'd0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; continuo = 1'b0;
    limite = 8'd0; fim_contador = 1'b0;
    #1;
    chk("reset", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_after_reset", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);

    // 1: limite=5, single shot
    limite = 8'd5;
    run_head("t1", 8'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_conta", 1'b0, 4'b0000, 1'b1, 8'(k), 1'b0, 1'b1);
    end
    tick();
    chk("t1_final", 1'b0, 4'b0000, 1'b0, 8'd5, 1'b1, 1'b1);
    tick();
    chk("t1_idle", 1'b0, 4'b0000, 1'b0, 8'd5, 1'b0, 1'b0);

    // 2: limite=10, fim_contador on 3rd conta cycle
    limite = 8'd10;
    run_head("t2", 8'd5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_conta", 1'b0, 4'b0000, 1'b1, 8'(k), 1'b0, 1'b1);
    end
    fim_contador = 1'b1;
    tick();
    fim_contador = 1'b0;
    chk("t2_final", 1'b0, 4'b0000, 1'b0, 8'd3, 1'b1, 1'b1);
    tick();
    chk("t2_idle", 1'b0, 4'b0000, 1'b0, 8'd3, 1'b0, 1'b0);

    // 3: limite=0 behaves as 1
    limite = 8'd0;
    run_head("t3", 8'd3);
    tick();
    chk("t3_conta", 1'b0, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b1);
    tick();
    chk("t3_final", 1'b0, 4'b0000, 1'b0, 8'd1, 1'b1, 1'b1);
    tick();
    chk("t3_idle", 1'b0, 4'b0000, 1'b0, 8'd1, 1'b0, 1'b0);

    // 4: continuous mode, limite=2
    limite = 8'd2;
    continuo = 1'b1;
    run_head("t4a", 8'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t4a_conta", 1'b0, 4'b0000, 1'b1, 8'(k), 1'b0, 1'b1);
    end
    limite = 8'd7;
    iniciar = 1'b1;
    tick();
    chk("t4a_final", 1'b0, 4'b0000, 1'b0, 8'd2, 1'b1, 1'b1);
    limite = 8'd2;
    iniciar = 1'b0;
    tick();
    chk("t4b_zera", 1'b1, 4'b0000, 1'b0, 8'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4b_reg", 1'b0, 4'(1 << i), 1'b0, 8'd0, 1'b0, 1'b1);
    end
    tick();
    chk("t4b_conta", 1'b0, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b1);
    limite = 8'd9;
    tick();
    chk("t4b_conta", 1'b0, 4'b0000, 1'b1, 8'd1, 1'b0, 1'b1);
    continuo = 1'b0;
    tick();
    chk("t4b_final", 1'b0, 4'b0000, 1'b0, 8'd2, 1'b1, 1'b1);
    tick();
    chk("t4b_idle", 1'b0, 4'b0000, 1'b0, 8'd2, 1'b0, 1'b0);

    // 5: parar during registra canal 2
    limite = 8'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("t5_zera", 1'b1, 4'b0000, 1'b0, 8'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_reg", 1'b0, 4'(1 << i), 1'b0, 8'd0, 1'b0, 1'b1);
    end
    parar = 1'b1;
    tick();
    parar = 1'b0;
    chk("t5_abort", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("t5_abort_hold", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
    run_head("t5r", 8'd0);
    tick();
    chk("t5r_conta", 1'b0, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b1);
    tick();
    chk("t5r_conta", 1'b0, 4'b0000, 1'b1, 8'd1, 1'b0, 1'b1);

    // 6: asynchronous reset mid-CONTA
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_reset", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle", 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
    end
    limite = 8'd1;
    run_head("t6r", 8'd0);
    tick();
    chk("t6r_conta", 1'b0, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b1);
    tick();
    chk("t6r_final", 1'b0, 4'b0000, 1'b0, 8'd1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unidade_controle_multicanal.md
Name: unidade_controle_multicanal

Overview:
Parametrised successor to the single-channel zera/registra/conta sequencer. It runs one measurement cycle on a start pulse:
- clears the datapath;
- strobes a registration enable to each of N_CANAIS channels in turn;
- runs an internal counter for a programmable number of cycles, or until an external end-of-count;
- signals completion.

It sits between the top-level control inputs and the datapath counters/registers. It supports single-shot and continuous (auto-restart) operation plus a synchronous abort.

Parameters:
N_CANAIS, 4, number of registration channels (1..16); width of registra bus.
LARGURA, 8, width of limite input and internal contagem counter.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
iniciar  input  1  start request, sampled only in INICIAL.
parar  input  1  synchronous abort, highest priority after reset.
continuo  input  1  mode select, sampled in FINAL: 1 = restart, 0 = return to idle.
limite  input  LARGURA  count length, latched in ZERA.
fim_contador  input  1  external end-of-count, honoured only in CONTA.
zera  output  1  datapath clear strobe.
registra  output  N_CANAIS  one-hot channel register enable.
conta  output  1  datapath count enable.
contagem  output  LARGURA  internal count value.
pronto  output  1  one-cycle completion pulse.
ocupado  output  1  high in every state except INICIAL.

Behaviour:
- Reset asserted (reset=0, asynchronous):
  - state=INICIAL; canal index=0; limite_reg=0; contagem=0.
  - All outputs 0.
  - Release is synchronous to the next clock edge; no output glitches.
- Outputs are Moore, decoded from registered state. No combinational input-to-output path.
- States and transitions:
  - INICIAL:
    - Outputs idle (all 0).
    - iniciar=1 -> ZERA. Otherwise stay.
  - ZERA (1 cycle):
    - zera=1; contagem<=0; canal<=0.
    - limite_reg<=limite, but limite=0 is stored as 1.
    - -> REGISTRA.
  - REGISTRA (N_CANAIS cycles):
    - registra = one-hot bit [canal].
    - canal increments each cycle.
    - After canal=N_CANAIS-1 -> CONTA, and canal returns to 0.
  - CONTA:
    - conta=1; contagem increments each cycle.
    - -> FINAL when contagem+1 == limite_reg, or when fim_contador=1. Whichever comes first wins; both together behave the same.
    - contagem still increments on the exit cycle.
  - FINAL (1 cycle):
    - pronto=1; contagem holds its value.
    - continuo=1 -> ZERA; continuo=0 -> INICIAL.
- parar=1 in any state other than INICIAL:
  - Next state INICIAL. pronto is not pulsed.
  - contagem holds its last value; canal is cleared.
- Latency with N_CANAIS=N and effective limite L:
  - iniciar sampled at edge t.
  - zera high during cycle t+1.
  - registra[0..N-1] during cycles t+2..t+N+1.
  - conta high for L cycles starting t+N+2.
  - pronto for one cycle at t+N+L+2.
- contagem arithmetic:
  - Unsigned, LARGURA bits.
  - It cannot wrap, because exit happens at limite_reg ≤ 2^LARGURA-1.
- limite changes after ZERA are ignored until the next ZERA.
- iniciar asserted outside INICIAL is ignored, including during FINAL.
- Continuous mode restart skips INICIAL. ocupado stays high across runs.

Optional Feature:
Macro UNIDADE_CONTROLE_DB_ESTADO_EN.
- Defined: adds output port db_estado [2:0] carrying the registered state code:
  - INICIAL=0, ZERA=1, REGISTRA=2, CONTA=3, FINAL=4.
  - Reset value 0.
- Undefined: the port does not exist. All other behaviour is identical.

Test Plan:
1. N_CANAIS=4, limite=5, continuo=0, pulse iniciar -> zera 1 cycle, then registra 0001, 0010, 0100, 1000 on consecutive cycles, conta high exactly 5 cycles, pronto 1 cycle with contagem=5, then ocupado=0.
2. limite=10, fim_contador=1 on the 3rd conta cycle -> FINAL next cycle, contagem=3, pronto 1 cycle.
3. limite=0 -> conta high exactly 1 cycle, contagem=1 at pronto.
4. continuo=1, limite=2 -> after pronto, zera is reasserted the next cycle and the sequence repeats. ocupado never drops. Set continuo=0 before the 2nd FINAL -> returns to INICIAL.
5. parar=1 during REGISTRA canal 2 -> next cycle all strobes 0, ocupado=0, no pronto. A new iniciar restarts from registra 0001.
6. reset=0 asserted mid-CONTA, asynchronously between edges -> all outputs 0 immediately, contagem=0. After release, idles until iniciar.
